// File: rtl/product_accumulator.sv
// ============================================================================
// product_accumulator : sums a programmed count of multiplier products
// Revision 1.0
// ============================================================================
`default_nettype none

module product_accumulator #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 48,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] length,
  input  logic                 mul_enable,
  input  logic [WIDTH-1:0]     product,
  output logic                 busy,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_prod_valid;
  logic [LEN_WIDTH-1:0]   r_remaining;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic                   r_overflow;
  logic                   r_busy;
  logic                   r_sum_valid;

  logic [ACC_WIDTH:0]     w_prod_ext;
  logic [ACC_WIDTH:0]     w_add;

  // One extra bit on the adder exposes the carry that feeds the sticky flag.
  always_comb begin
    w_prod_ext              = '0;
    w_prod_ext[WIDTH-1:0]   = product;
  end

  assign w_add = {1'b0, r_acc} + w_prod_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_prod_valid <= 1'b0;
      r_remaining  <= '0;
      r_acc        <= '0;
      r_overflow   <= 1'b0;
      r_busy       <= 1'b0;
      r_sum_valid  <= 1'b0;
    end else begin
      r_prod_valid <= mul_enable;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            if (length != '0) begin
              r_remaining <= length;
              r_state     <= ST_ACCUM;
            end else begin
              r_sum_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end
          end
        end
        ST_ACCUM: begin
          if (r_prod_valid) begin
            r_acc       <= w_add[ACC_WIDTH-1:0];
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            if (w_add[ACC_WIDTH]) begin
              r_overflow <= 1'b1;
            end
            if (r_remaining == LEN_WIDTH'(1)) begin
              r_sum_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (sum_ready) begin
            r_sum_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_sum_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign sum       = r_acc;
  assign sum_valid = r_sum_valid;
  assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ============================================================================
// tb_product_accumulator : directed + randomized bench with a run-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_product_accumulator;

  localparam int W   = 32;
  localparam int AW  = 48;
  localparam int AW2 = 33;
  localparam int LW  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] length;
  logic          mul_enable;
  logic [W-1:0]  product;
  logic          sum_ready;

  logic          busy_a, sv_a, ovf_a;
  logic [AW-1:0] sum_a;
  logic          busy_b, sv_b, ovf_b;
  logic [AW2-1:0] sum_b;

  int checks   = 0;
  int failures = 0;

  logic [31:0]     vals[$];
  int              gaps[$];
  longint unsigned tot;

  always #5 clk = ~clk;

  product_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .mul_enable(mul_enable), .product(product), .busy(busy_a),
    .sum(sum_a), .sum_valid(sv_a), .sum_ready(sum_ready), .overflow(ovf_a)
  );

  // Narrow accumulator copy driven identically, used to reach wrap quickly.
  product_accumulator #(.WIDTH(W), .ACC_WIDTH(AW2), .LEN_WIDTH(LW)) u_dut33 (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .mul_enable(mul_enable), .product(product), .busy(busy_b),
    .sum(sum_b), .sum_valid(sv_b), .sum_ready(sum_ready), .overflow(ovf_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wrapv(input longint unsigned t, input int aw);
    return t & ((64'd1 << aw) - 64'd1);
  endfunction

  // Inputs held across one rising edge; the multiplier result appears after it.
  task automatic step(input bit st, input logic [LW-1:0] len, input bit en,
                      input logic [W-1:0] d, input bit rdy);
    start      = st;
    length     = len;
    mul_enable = en;
    sum_ready  = rdy;
    @(posedge clk);
    #1;
    product = en ? d : W'($urandom);
  endtask

  task automatic check_out();
    chk("sum48", sum_a, wrapv(tot, AW));
    chk("sum33", sum_b, wrapv(tot, AW2));
    chk("ovf48", ovf_a, tot >= (64'd1 << AW));
    chk("ovf33", ovf_b, tot >= (64'd1 << AW2));
  endtask

  task automatic check_reset();
    chk("rst_busy", busy_a, 0);
    chk("rst_sv", sv_a, 0);
    chk("rst_sum", sum_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_busy33", busy_b, 0);
    chk("rst_sv33", sv_b, 0);
    chk("rst_sum33", sum_b, 0);
    chk("rst_ovf33", ovf_b, 0);
  endtask

  // Start on the first enable, then feed vals[] with gaps[] idle cycles before each.
  task automatic feed(input bit ign, input bit rdy);
    tot = 0;
    foreach (vals[i]) begin
      for (int g = 0; g < gaps[i]; g++) step(ign, 16'd9, 1'b0, '0, rdy);
      if (i == 0) step(1'b1, LW'(vals.size()), 1'b1, vals[i], rdy);
      else        step(ign, 16'd9, 1'b1, vals[i], rdy);
      tot += vals[i];
    end
    chk("busy_accum", busy_a, 1);
    chk("sv_before_last", sv_a, 0);
    step(ign, 16'd9, 1'b0, '0, rdy);
    chk("sv_result", sv_a, 1);
    chk("busy_hold", busy_a, 1);
    check_out();
  endtask

  task automatic accept(input int hold, input bit ign);
    for (int h = 0; h < hold; h++) begin
      step(ign, 16'd9, 1'b0, '0, 1'b0);
      chk("sv_held", sv_a, 1);
      check_out();
    end
    step(ign, 16'd9, 1'b0, '0, 1'b1);
    chk("sv_drop", sv_a, 0);
    chk("busy_idle", busy_a, 0);
    check_out();
    step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("no_restart", busy_a, 0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1 check_reset();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; length = '0; mul_enable = 1'b0;
    product = '0; sum_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    reset = 1'b0;

    // back-to-back, ready high throughout
    vals = '{32'd3, 32'd5, 32'd7, 32'd9}; gaps = '{0, 0, 0, 0};
    feed(1'b0, 1'b1);
    chk("sum24", sum_a, 48'd24);
    accept(0, 1'b0);

    // gapped products, consumer stalls 5 cycles
    vals = '{32'd10, 32'd20, 32'd30}; gaps = '{0, 2, 4};
    feed(1'b0, 1'b0);
    chk("sum60", sum_a, 48'd60);
    accept(5, 1'b0);

    // wrap on the narrow accumulator
    vals = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}; gaps = '{0, 0, 0};
    feed(1'b0, 1'b0);
    chk("wrap33", sum_b, 33'h0_FFFF_FFFD);
    chk("ovf33_set", ovf_b, 1);
    accept(1, 1'b0);

    // products in IDLE are ignored, then zero-length run
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 32'd123, 1'b0);
    check_out();
    step(1'b1, '0, 1'b0, '0, 1'b0);
    tot = 0;
    chk("zero_sv", sv_a, 1);
    chk("zero_sum", sum_a, 0);
    chk("ovf33_cleared", ovf_b, 0);
    accept(0, 1'b0);

    // start pulses during ACCUM and HOLD are ignored
    vals.delete(); gaps.delete();
    for (int i = 0; i < 4; i++) begin
      vals.push_back($urandom);
      gaps.push_back(i == 0 ? 0 : int'($urandom_range(0, 2)));
    end
    feed(1'b1, 1'b0);
    accept(2, 1'b1);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      vals.delete(); gaps.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        vals.push_back($urandom);
        gaps.push_back(i == 0 ? 0 : int'($urandom_range(0, 3)));
      end
      feed(1'b0, 1'($urandom_range(0, 1)));
      accept(int'($urandom_range(0, 3)), 1'b0);
    end

    // reset mid-run discards the partial sum
    vals = '{32'd11, 32'd22};
    step(1'b1, 16'd5, 1'b1, vals[0], 1'b0);
    step(1'b0, '0, 1'b1, vals[1], 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("partial_sum", sum_a, 48'd33);
    chk("partial_busy", busy_a, 1);
    pulse_reset();
    vals = '{32'd7}; gaps = '{0};
    feed(1'b0, 1'b0);
    chk("sum7", sum_a, 48'd7);
    accept(0, 1'b0);

    // maximum length keeps accumulating without completing
    step(1'b1, 16'hFFFF, 1'b1, 32'd1000, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 32'd1000, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("maxlen_busy", busy_a, 1);
    chk("maxlen_sv", sv_a, 0);
    chk("maxlen_sum", sum_a, 48'd5000);
    pulse_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/product_accumulator.md
# product_accumulator

Downstream stage of the AXI multiplier accelerator: consumes the 32-bit product the multiplier registers one cycle after its `enable`, and sums a programmed number of products into a wide accumulator. The finished sum is presented on a valid/ready output to the AXI register interface, so software can run dot products without reading every product back. Accumulator overflow is reported through a sticky flag.

## Interface
- `WIDTH`, 32: width of the multiplier product input.
- `ACC_WIDTH`, 48: accumulator and sum width; must be ≥ `WIDTH`.
- `LEN_WIDTH`, 16: width of the product-count field.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle request to begin a new accumulation.
- `length`  in  LEN_WIDTH  number of products to sum; sampled with `start`.
- `mul_enable`  in  1  the same signal that drives the multiplier enable.
- `product`  in  WIDTH  multiplier output; unsigned.
- `busy`  out  1  high in ACCUM and HOLD.
- `sum`  out  ACC_WIDTH  accumulated result; stable while `sum_valid` is high.
- `sum_valid`  out  1  result available.
- `sum_ready`  in  1  consumer accepts the result.
- `overflow`  out  1  sticky; set when any addition carries out of `ACC_WIDTH`.

## Operation
Internal signals:
- `prod_valid` is a register: `prod_valid <= mul_enable` every cycle, in all states. It matches the multiplier's one-cycle latency, so `prod_valid == 1` marks a cycle in which `product` is new.
- `remaining` is a LEN_WIDTH down-counter.
- `acc` is the ACC_WIDTH accumulator and drives `sum`.

State machine (IDLE, ACCUM, HOLD):
- **IDLE**
  - `start` with `length != 0` -> ACCUM. Load `acc = 0`, `remaining = length`, clear `overflow`.
  - `start` with `length == 0` -> HOLD. Load `acc = 0`, clear `overflow`.
  - `prod_valid` is ignored.
- **ACCUM**
  - On each cycle with `prod_valid`: `acc <= acc + zero_extend(product)` and `remaining <= remaining - 1`.
  - When this decrement takes `remaining` from 1 to 0 -> HOLD.
  - Cycles without `prod_valid` hold all state.
  - `start` is ignored.
- **HOLD**
  - `sum_valid = 1`.
  - `sum_ready` high -> IDLE. `acc` keeps its value; `sum` keeps showing the last result.
  - `prod_valid` and `start` are ignored.

Arithmetic:
- `product` is unsigned and is zero-extended to `ACC_WIDTH`.
- The addition wraps modulo 2^ACC_WIDTH.
- The carry out sets `overflow`, which stays set until the next accepted `start` or `reset`.

## Timing
Reset values: state IDLE, `acc = 0`, `remaining = 0`, `prod_valid = 0`, `busy = 0`, `sum = 0`, `sum_valid = 0`, `overflow = 0`.

Start and first product:
- `start` at edge t moves the FSM to ACCUM at t+1.
- `mul_enable` high in the cycle ending at edge t gives `prod_valid = 1` in the cycle after edge t. That product is counted, because the FSM is in ACCUM during that cycle.
- Software therefore issues `start` no later than the first `mul_enable`.

Result latency:
- `sum_valid` rises in the cycle after the edge that adds the last product.
- With back-to-back enables, `sum_valid` comes `length + 1` cycles after `start`.

Handshake:
- The transfer completes on the edge where `sum_valid && sum_ready`.
- `sum_valid` drops in the next cycle.
- `sum_ready` held high in HOLD gives a one-cycle `sum_valid` pulse.
- `sum_valid` never depends combinationally on `sum_ready`.

Boundary conditions:
- **`start` during the HOLD->IDLE edge:** ignored. A new `start` is accepted only in a cycle where the state is IDLE.
- **Max `length`:** `length = 2^LEN_WIDTH - 1` is legal.
- **Zero `length`:** `length = 0` reaches HOLD in one cycle, with `sum = 0`.
- **Reset mid-operation:** asynchronous return to reset values. A partial sum is discarded and no `sum_valid` is produced.
- **Gaps:** gaps in `mul_enable` stretch ACCUM with no loss of products.

## Test plan
- **Back-to-back run:** reset, then `start`, `length = 4`, and products 3, 5, 7, 9 on consecutive `prod_valid` cycles, with `sum_ready = 1` -> `sum = 24`, and `sum_valid` for exactly one cycle at `start + 5`.
- **Gapped products:** `length = 3`, products 10, 20, 30 with idle gaps of 2 and 4 cycles, and `sum_ready` held low for 5 cycles -> `sum = 60`, held stable with `sum_valid` high until `sum_ready` rises, then `busy = 0`.
- **Overflow wrap:** `ACC_WIDTH = 33`, `length = 3`, product `0xFFFFFFFF` three times -> `sum = 0x0FFFFFFFD` (mod 2^33) and `overflow = 1`. The next `start` clears `overflow`.
- **Zero length:** `start` with `length = 0` -> `sum_valid` at `start + 1` with `sum = 0`. Products arriving in IDLE do not change `sum`.
- **Reset mid-run:** `length = 5`, two products accepted, then `reset` pulsed between edges -> outputs return to reset values immediately. A following `length = 1` run with product 7 gives `sum = 7`.
- **Ignored `start`:** `start` pulsed with `length = 9` during ACCUM and again during HOLD -> the current run completes with its original count, and no second run begins.
